// File: rtl/seq_subtractor_pkg.sv
// seq_subtractor_pkg: state type and chunk-count helper for the chunk-serial subtractor
package seq_subtractor_pkg;
`include "seq_sub_defs.vh"
  typedef enum logic [1:0] {
    IDLE = `ST_IDLE,
    RUN  = `ST_RUN,
    DONE = `ST_DONE
  } state_t;
  function automatic int nchunk(input int w, input int c);
    return (w + c - 1) / c;
  endfunction
endpackage

// File: rtl/seq_sub_defs.vh
// seq_sub_defs: FSM state encodings shared by the subtractor and its bench
`ifndef SEQ_SUB_DEFS_VH
`define SEQ_SUB_DEFS_VH
`define ST_IDLE 2'd0
`define ST_RUN  2'd1
`define ST_DONE 2'd2
`endif

// File: rtl/sub_chunk.sv
// sub_chunk: combinational chunk subtract {bo,d} = x - y - bi
module sub_chunk #(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] x,
  input  logic [CHUNK-1:0] y,
  input  logic             bi,
  output logic [CHUNK-1:0] d,
  output logic             bo
);
  assign {bo, d} = {1'b0, x} - {1'b0, y} - {{CHUNK{1'b0}}, bi};
endmodule

// File: rtl/seq_subtractor.sv
// seq_subtractor: handshaked chunk-serial a - b - bin with borrow-out
module seq_subtractor
  import seq_subtractor_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout
);
  localparam int NCHUNK = nchunk(WIDTH, CHUNK);
  localparam int PW = NCHUNK * CHUNK;
  state_t state, nxt;
  logic [PW-1:0] opa, opb;
  logic brw, last, accept, cb;
  logic [CHUNK-1:0] cd;
  assign accept = in_valid && in_ready;
  assign in_ready = state == IDLE;
  assign out_valid = state == DONE;
  assign bout = brw;
  // state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= nxt;
  // next state: accept, run until the last chunk, hold result until taken
  always_comb begin
    nxt = state == IDLE ? (in_valid ? RUN : IDLE) :
          state == RUN  ? (last ? DONE : RUN) :
                          (out_ready ? IDLE : DONE);
  end
  // operands are captured zero-padded once; borrow chains chunk to chunk
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      opa <= '0;
      opb <= '0;
      brw <= 1'b0;
    end else if (accept) begin
      opa <= PW'(a);
      opb <= PW'(b);
      brw <= bin;
    end else if (state == RUN) brw <= cb;
  generate
    case (NCHUNK)
      1: begin : sub
        sub_chunk #(.CHUNK(CHUNK)) core (.x(opa), .y(opb), .bi(brw), .d(cd), .bo(cb));
        assign last = 1'b1;
        // whole result lands in the single run cycle; padded bits dropped
        always_ff @(posedge clk or negedge rst_n)
          if (!rst_n) diff <= '0;
          else if (state == RUN) diff <= cd[WIDTH-1:0];
      end
      default: begin : sub
        localparam int KW = $clog2(NCHUNK);
        logic [KW-1:0] k;
        sub_chunk #(.CHUNK(CHUNK)) core (
          .x(opa[k*CHUNK +: CHUNK]), .y(opb[k*CHUNK +: CHUNK]), .bi(brw), .d(cd), .bo(cb)
        );
        assign last = k == KW'(NCHUNK - 1);
        // write chunk k into its slice of diff (truncated at WIDTH), advance k without wrapping
        always_ff @(posedge clk or negedge rst_n)
          if (!rst_n) begin
            k <= '0;
            diff <= '0;
          end else if (accept) k <= '0;
          else if (state == RUN) begin
            for (int i = 0; i < WIDTH; i++)
              if (i / CHUNK == int'(k)) diff[i] <= cd[i % CHUNK];
            if (!last) k <= k + 1'b1;
          end
      end
    endcase
  endgenerate
endmodule

// File: tb/tb_seq_subtractor.sv
// tb_seq_subtractor: randomized and directed checks of three subtractor widths against an arithmetic model
`include "seq_sub_defs.vh"
module tb_seq_subtractor;
  logic clk = 0, rst_n, in_valid, out_ready, bin;
  logic [9:0] a, b;
  logic [2:0] rdy, vld, bo;
  logic [7:0] diff8;
  logic diff1;
  logic [9:0] diff10;
  int checks = 0, errors = 0;
  int wd[3] = '{8, 1, 10};
  int lat[3] = '{2, 1, 3};
  always #5 clk = ~clk;
  seq_subtractor #(.WIDTH(8), .CHUNK(4)) d8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy[0]), .a(a[7:0]), .b(b[7:0]),
    .bin(bin), .out_valid(vld[0]), .out_ready(out_ready), .diff(diff8), .bout(bo[0]));
  seq_subtractor #(.WIDTH(1), .CHUNK(4)) d1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy[1]), .a(a[0]), .b(b[0]),
    .bin(bin), .out_valid(vld[1]), .out_ready(out_ready), .diff(diff1), .bout(bo[1]));
  seq_subtractor #(.WIDTH(10), .CHUNK(4)) d10 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy[2]), .a(a), .b(b),
    .bin(bin), .out_valid(vld[2]), .out_ready(out_ready), .diff(diff10), .bout(bo[2]));
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask
  function automatic logic [31:0] gdiff(input int i);
    return i == 0 ? 32'(diff8) : i == 1 ? 32'(diff1) : 32'(diff10);
  endfunction
  function automatic logic [31:0] mdiff(input int w, input logic [9:0] x, y, input logic c);
    int m = (1 << w) - 1;
    return 32'(((int'(x) & m) - (int'(y) & m) - int'(c)) & m);
  endfunction
  function automatic logic mbout(input int w, input logic [9:0] x, y, input logic c);
    int m = (1 << w) - 1;
    return (int'(x) & m) < (int'(y) & m) + int'(c);
  endfunction
  task automatic op(input logic [9:0] oa, ob, input logic obin, input int hold);
    int n = 0;
    int seen[3] = '{0, 0, 0};
    while (rdy != 3'b111 && n < 10) begin
      @(posedge clk); #1; n++;
    end
    chk("idle_wait", 32'(rdy), 32'h7);
    a = oa; b = ob; bin = obin; in_valid = 1; out_ready = 0;
    @(posedge clk); #1;
    in_valid = 0; a = 10'($urandom); b = 10'($urandom); bin = 1'($urandom);
    for (int c = 1; c <= 4; c++) begin
      @(posedge clk); #1;
      for (int i = 0; i < 3; i++) if (vld[i] && seen[i] == 0) seen[i] = c;
    end
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("lat_w%0d", wd[i]), 32'(seen[i]), 32'(lat[i]));
      chk($sformatf("diff_w%0d", wd[i]), gdiff(i), mdiff(wd[i], oa, ob, obin));
      chk($sformatf("bout_w%0d", wd[i]), 32'(bo[i]), 32'(mbout(wd[i], oa, ob, obin)));
    end
    for (int h = 0; h < hold; h++) begin
      in_valid = 1'($urandom); a = 10'($urandom); b = 10'($urandom);
      @(posedge clk); #1;
      chk("hold_state", 32'(d8.state), 32'(`ST_DONE));
      for (int i = 0; i < 3; i++) begin
        chk($sformatf("hold_vld_w%0d", wd[i]), 32'(vld[i]), 1);
        chk($sformatf("hold_rdy_w%0d", wd[i]), 32'(rdy[i]), 0);
        chk($sformatf("hold_diff_w%0d", wd[i]), gdiff(i), mdiff(wd[i], oa, ob, obin));
        chk($sformatf("hold_bout_w%0d", wd[i]), 32'(bo[i]), 32'(mbout(wd[i], oa, ob, obin)));
      end
    end
    in_valid = 0; out_ready = 1;
    @(posedge clk); #1;
    out_ready = 0;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("rel_rdy_w%0d", wd[i]), 32'(rdy[i]), 1);
      chk($sformatf("rel_vld_w%0d", wd[i]), 32'(vld[i]), 0);
    end
  endtask
  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1);
  end
  initial begin
    rst_n = 0; in_valid = 0; out_ready = 0; a = '0; b = '0; bin = 0;
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("rst_rdy_w%0d", wd[i]), 32'(rdy[i]), 1);
      chk($sformatf("rst_vld_w%0d", wd[i]), 32'(vld[i]), 0);
      chk($sformatf("rst_diff_w%0d", wd[i]), gdiff(i), 0);
      chk($sformatf("rst_bout_w%0d", wd[i]), 32'(bo[i]), 0);
    end
    @(negedge clk) rst_n = 1;
    op(10'h035, 10'h012, 0, 0);
    op(10'h000, 10'h001, 0, 0);
    op(10'h000, 10'h000, 1, 0);
    chk("core_w1", 32'(d1.sub.core.bo), 1);
    chk("core_w8", 32'(d8.sub.core.bo), 1);
    op(10'h3ff, 10'h3ff, 1, 5);
    op(10'h2a5, 10'h15a, 0, 5);
    a = 10'h000; b = 10'h001; bin = 0; in_valid = 1;
    @(posedge clk); #1;
    in_valid = 0;
    @(negedge clk) rst_n = 0;
    #1;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("midrst_rdy_w%0d", wd[i]), 32'(rdy[i]), 1);
      chk($sformatf("midrst_vld_w%0d", wd[i]), 32'(vld[i]), 0);
      chk($sformatf("midrst_diff_w%0d", wd[i]), gdiff(i), 0);
    end
    @(negedge clk) rst_n = 1;
    op(10'h010, 10'h001, 0, 0);
    for (int t = 0; t < 25; t++) op(10'($urandom), 10'($urandom), 1'($urandom), int'($urandom_range(0, 2)));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
